// File: rtl/color_channel_select.sv
// Pixel-channel selector: RGB565 in, one 8-bit channel out (gray/R/G/B/Y/Cr/Cb/inverted gray),
// with a per-pixel in-band mask and a per-frame masked-pixel count. Requires CONV_LATENCY >= 2.
module color_channel_select #(
  parameter int unsigned CONV_LATENCY = 3,
  parameter int unsigned HCOUNT_W     = 11,
  parameter int unsigned VCOUNT_W     = 10,
  parameter int unsigned COUNT_W      = 20
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [15:0]         rec_pixel,
  input  logic                rec_valid,
  input  logic [HCOUNT_W-1:0] rec_hcount,
  input  logic [VCOUNT_W-1:0] rec_vcount,
  input  logic [2:0]          selector,
  input  logic [7:0]          lower_bound,
  input  logic [7:0]          upper_bound,
  output logic [7:0]          result_pixel,
  output logic                result_mask,
  output logic                result_valid,
  output logic [HCOUNT_W-1:0] result_hcount,
  output logic [VCOUNT_W-1:0] result_vcount,
  output logic [COUNT_W-1:0]  frame_count_out,
  output logic                frame_count_valid
);

  localparam int unsigned TailDepth = CONV_LATENCY - 1;
  localparam logic [COUNT_W-1:0] AccOne = COUNT_W'(1);

  typedef enum logic [2:0] {
    ModeGray = 3'b000,
    ModeR    = 3'b001,
    ModeG    = 3'b010,
    ModeB    = 3'b011,
    ModeY    = 3'b100,
    ModeCr   = 3'b101,
    ModeCb   = 3'b110,
    ModeInv  = 3'b111
  } mode_e;

  // Per-pixel sideband that travels with the data so band settings never mix across frames.
  typedef struct packed {
    logic                vld;
    logic [HCOUNT_W-1:0] hc;
    logic [VCOUNT_W-1:0] vc;
    logic [7:0]          lo;
    logic [7:0]          hi;
  } tag_t;

  // Frame-latched settings
  mode_e      active_mode_q, active_mode_d;
  logic [7:0] lo_q, lo_d, hi_q, hi_d;

  // Stage 0: channel expansion and YCrCb weighted sums
  tag_t               tag0_q;
  mode_e              mode0_q;
  logic [7:0]         r0_q, g0_q, b0_q;
  logic signed [17:0] y0_q, cr0_q, cb0_q;

  // Tail stages: selected value only
  tag_t       tag_q [TailDepth];
  logic [7:0] val_q [TailDepth];

  // Output stage
  logic [7:0]          pixel_q;
  logic                mask_q, valid_q;
  logic [HCOUNT_W-1:0] hc_q;
  logic [VCOUNT_W-1:0] vc_q;
  logic [COUNT_W-1:0]  acc_q, acc_d, fco_q, fco_d;
  logic                fcv_q, fcv_d, first_q, first_d;

  // Input stage
  logic               sof_in;
  mode_e              mode_in;
  tag_t               tag_in;
  logic [7:0]         r_in, g_in, b_in;
  logic signed [17:0] r_s, g_s, b_s, y_in, cr_in, cb_in;

  always_comb begin
    sof_in        = rec_valid && (rec_hcount == '0) && (rec_vcount == '0);
    active_mode_d = sof_in ? mode_e'(selector) : active_mode_q;
    lo_d          = sof_in ? lower_bound : lo_q;
    hi_d          = sof_in ? upper_bound : hi_q;
    mode_in       = active_mode_d;
    tag_in        = '{vld: rec_valid, hc: rec_hcount, vc: rec_vcount, lo: lo_d, hi: hi_d};
    r_in          = {rec_pixel[15:11], 3'b000};
    g_in          = {rec_pixel[10:5], 2'b00};
    b_in          = {rec_pixel[4:0], 3'b000};
    r_s           = $signed({10'd0, r_in});
    g_s           = $signed({10'd0, g_in});
    b_s           = $signed({10'd0, b_in});
    // BT.601 full-range, 8 fractional bits
    y_in          = 18'sd77 * r_s + 18'sd150 * g_s + 18'sd29 * b_s;
    cr_in         = 18'sd128 * r_s - 18'sd107 * g_s - 18'sd21 * b_s;
    cb_in         = 18'sd128 * b_s - 18'sd43 * r_s - 18'sd85 * g_s;
  end

  // Stage 1: finish conversion and select the channel
  logic [9:0] sum1;
  logic [7:0] gray1, y1, cr1, cb1, val1;

  always_comb begin
    sum1  = {2'b00, r0_q} + {2'b00, g0_q} + {2'b00, b0_q};
    gray1 = 8'((sum1 >> 2) + (sum1 >> 4) + (sum1 >> 6));
    y1    = 8'(y0_q >>> 8);
    cr1   = 8'((cr0_q >>> 8) + 18'sd128);
    cb1   = 8'((cb0_q >>> 8) + 18'sd128);
    val1  = gray1;
    unique case (mode0_q)
      ModeGray: val1 = gray1;
      ModeR:    val1 = r0_q;
      ModeG:    val1 = g0_q;
      ModeB:    val1 = b0_q;
      ModeY:    val1 = y1;
      ModeCr:   val1 = cr1;
      ModeCb:   val1 = cb1;
      ModeInv:  val1 = 8'd255 - gray1;
    endcase
  end

  // Output stage: mask and frame counter
  tag_t       tl;
  logic [7:0] vl;
  logic       in_band, mask_out, sof_out;

  always_comb begin
    tl       = tag_q[TailDepth-1];
    vl       = val_q[TailDepth-1];
    in_band  = (tl.lo <= tl.hi) ? ((vl >= tl.lo) && (vl <= tl.hi))
                                : ((vl >= tl.lo) || (vl <= tl.hi));
    mask_out = tl.vld && in_band;
    sof_out  = tl.vld && (tl.hc == '0) && (tl.vc == '0);

    acc_d   = acc_q;
    fco_d   = fco_q;
    fcv_d   = 1'b0;
    first_d = first_q;
    if (sof_out) begin
      acc_d   = mask_out ? AccOne : '0;
      first_d = 1'b0;
      // No complete frame precedes the first SOF after reset
      if (!first_q) begin
        fco_d = acc_q;
        fcv_d = 1'b1;
      end
    end else if (mask_out && (acc_q != '1)) begin
      acc_d = acc_q + AccOne;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      active_mode_q <= ModeGray;
      lo_q          <= 8'd0;
      hi_q          <= 8'd255;
      tag0_q        <= '0;
      mode0_q       <= ModeGray;
      r0_q          <= '0;
      g0_q          <= '0;
      b0_q          <= '0;
      y0_q          <= '0;
      cr0_q         <= '0;
      cb0_q         <= '0;
      for (int unsigned i = 0; i < TailDepth; i++) begin
        tag_q[i] <= '0;
        val_q[i] <= '0;
      end
      pixel_q <= '0;
      mask_q  <= 1'b0;
      valid_q <= 1'b0;
      hc_q    <= '0;
      vc_q    <= '0;
      acc_q   <= '0;
      fco_q   <= '0;
      fcv_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      active_mode_q <= active_mode_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      tag0_q        <= tag_in;
      mode0_q       <= mode_in;
      r0_q          <= r_in;
      g0_q          <= g_in;
      b0_q          <= b_in;
      y0_q          <= y_in;
      cr0_q         <= cr_in;
      cb0_q         <= cb_in;
      tag_q[0]      <= tag0_q;
      val_q[0]      <= val1;
      for (int unsigned i = 1; i < TailDepth; i++) begin
        tag_q[i] <= tag_q[i-1];
        val_q[i] <= val_q[i-1];
      end
      pixel_q <= tl.vld ? vl : '0;
      mask_q  <= mask_out;
      valid_q <= tl.vld;
      hc_q    <= tl.vld ? tl.hc : '0;
      vc_q    <= tl.vld ? tl.vc : '0;
      acc_q   <= acc_d;
      fco_q   <= fco_d;
      fcv_q   <= fcv_d;
      first_q <= first_d;
    end
  end

  assign result_pixel      = pixel_q;
  assign result_mask       = mask_q;
  assign result_valid      = valid_q;
  assign result_hcount     = hc_q;
  assign result_vcount     = vc_q;
  assign frame_count_out   = fco_q;
  assign frame_count_valid = fcv_q;

endmodule

// File: tb/tb_color_channel_select.sv
// Directed bench for color_channel_select: modes, latency, frame-start latching, mask band,
// frame counter and mid-frame reset.
module tb_color_channel_select;

  localparam int L = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] rec_pixel;
  logic        rec_valid;
  logic [10:0] rec_hcount;
  logic [9:0]  rec_vcount;
  logic [2:0]  selector;
  logic [7:0]  lower_bound, upper_bound;
  logic [7:0]  result_pixel;
  logic        result_mask, result_valid;
  logic [10:0] result_hcount;
  logic [9:0]  result_vcount;
  logic [19:0] frame_count_out;
  logic        frame_count_valid;

  always #5 clk_in = ~clk_in;

  color_channel_select #(
    .CONV_LATENCY(3),
    .HCOUNT_W(11),
    .VCOUNT_W(10),
    .COUNT_W(20)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rec_pixel(rec_pixel),
    .rec_valid(rec_valid),
    .rec_hcount(rec_hcount),
    .rec_vcount(rec_vcount),
    .selector(selector),
    .lower_bound(lower_bound),
    .upper_bound(upper_bound),
    .result_pixel(result_pixel),
    .result_mask(result_mask),
    .result_valid(result_valid),
    .result_hcount(result_hcount),
    .result_vcount(result_vcount),
    .frame_count_out(frame_count_out),
    .frame_count_valid(frame_count_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic        st_rst [32];
  logic        st_v   [32];
  logic [15:0] st_pix [32];
  logic [10:0] st_hc  [32];
  logic [9:0]  st_vc  [32];
  logic [2:0]  st_sel [32];
  logic [7:0]  st_lo  [32];
  logic [7:0]  st_hi  [32];

  logic        obs_v   [40];
  logic [7:0]  obs_pix [40];
  logic        obs_m   [40];
  logic [10:0] obs_hc  [40];
  logic [9:0]  obs_vc  [40];
  logic [19:0] obs_fco [40];
  logic        obs_fcv [40];

  task automatic put(input int i, input logic rst, input logic v, input logic [15:0] p,
                     input int hc, input int vc, input logic [2:0] sel,
                     input logic [7:0] lo, input logic [7:0] hi);
    st_rst[i] = rst;
    st_v[i]   = v;
    st_pix[i] = p;
    st_hc[i]  = 11'(hc);
    st_vc[i]  = 10'(vc);
    st_sel[i] = sel;
    st_lo[i]  = lo;
    st_hi[i]  = hi;
  endtask

  // Entry k is sampled at the edge ending sample slot k; its result lands in slot k+L-1.
  task automatic run(input int n);
    for (int k = 0; k < n + L; k++) begin
      if (k < n) begin
        rst_in      = st_rst[k];
        rec_valid   = st_v[k];
        rec_pixel   = st_pix[k];
        rec_hcount  = st_hc[k];
        rec_vcount  = st_vc[k];
        selector    = st_sel[k];
        lower_bound = st_lo[k];
        upper_bound = st_hi[k];
      end else begin
        rst_in    = 1'b1;
        rec_valid = 1'b0;
      end
      @(posedge clk_in);
      #1;
      obs_v[k]   = result_valid;
      obs_pix[k] = result_pixel;
      obs_m[k]   = result_mask;
      obs_hc[k]  = result_hcount;
      obs_vc[k]  = result_vcount;
      obs_fco[k] = frame_count_out;
      obs_fcv[k] = frame_count_valid;
    end
    rst_in    = 1'b1;
    rec_valid = 1'b0;
  endtask

  task automatic test_reset();
    int nv;
    put(0, 1'b0, 1'b1, 16'hFFFF, 0, 0, 3'd1, 8'd0, 8'd255);
    put(1, 1'b0, 1'b1, 16'hFFFF, 1, 0, 3'd1, 8'd0, 8'd255);
    put(2, 1'b0, 1'b0, 16'hFFFF, 2, 0, 3'd1, 8'd0, 8'd255);
    run(3);
    n_checks++;
    if (obs_v[2] !== 1'b0 || obs_pix[2] !== 8'd0 || obs_m[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b pix=%0d m=%b exp v=0 pix=0 m=0",
               obs_v[2], obs_pix[2], obs_m[2]);
    end
    n_checks++;
    if (obs_fco[2] !== 20'd0 || obs_fcv[2] !== 1'b0 || obs_hc[2] !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_count got fco=%0d fcv=%b hc=%0d exp 0/0/0",
               obs_fco[2], obs_fcv[2], obs_hc[2]);
    end
    nv = 0;
    for (int k = 0; k < 3 + L; k++) if (obs_v[k] !== 1'b0) nv++;
    n_checks++;
    if (nv != 0) begin
      n_fail++;
      $display("FAIL reset_discard got valid_slots=%0d exp 0", nv);
    end
  endtask

  localparam logic [15:0] MP [13] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                      16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hF800, 16'hF800,
                                      16'hF800, 16'hF800, 16'hF800};
  localparam logic [2:0]  MS [13] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                                      3'd4, 3'd5, 3'd6, 3'd0, 3'd7};
  localparam logic [7:0]  ME [13] = '{8'd244, 8'd248, 8'd252, 8'd248, 8'd250, 8'd126, 8'd126,
                                      8'd11, 8'd74, 8'd252, 8'd86, 8'd80, 8'd175};

  task automatic test_modes();
    for (int i = 0; i < 13; i++) begin
      put(0, 1'b1, 1'b1, MP[i], 0, 0, MS[i], 8'd0, 8'd255);
      run(1);
      n_checks++;
      if (obs_v[L-2] !== 1'b0 || obs_v[L-1] !== 1'b1) begin
        n_fail++;
        $display("FAIL mode%0d_latency got v[L-2]=%b v[L-1]=%b exp 0/1", i, obs_v[L-2],
                 obs_v[L-1]);
      end
      n_checks++;
      if (obs_pix[L-1] !== ME[i]) begin
        n_fail++;
        $display("FAIL mode%0d_pixel got=%0d exp=%0d", i, obs_pix[L-1], ME[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    put(0, 1'b1, 1'b1, 16'hFFFF, 0, 0, 3'd4, 8'd0, 8'd255);
    put(1, 1'b1, 1'b1, 16'hFFFF, 0, 0, 3'd0, 8'd0, 8'd255);
    put(2, 1'b1, 1'b1, 16'hFFFF, 1, 0, 3'd4, 8'd0, 8'd255);
    put(3, 1'b1, 1'b0, 16'hFFFF, 2, 0, 3'd4, 8'd0, 8'd255);
    put(4, 1'b1, 1'b1, 16'hF800, 0, 0, 3'd5, 8'd0, 8'd255);
    run(5);
    n_checks++;
    if (obs_v[2] !== 1'b0 || obs_v[3] !== 1'b1 || obs_v[4] !== 1'b1 || obs_v[5] !== 1'b1
        || obs_v[6] !== 1'b0 || obs_v[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_valid got=%b%b%b%b%b%b exp=011101", obs_v[2], obs_v[3], obs_v[4],
               obs_v[5], obs_v[6], obs_v[7]);
    end
    n_checks++;
    if (obs_pix[3] !== 8'd250 || obs_pix[4] !== 8'd244 || obs_pix[5] !== 8'd244
        || obs_pix[7] !== 8'd252) begin
      n_fail++;
      $display("FAIL b2b_pixel got=%0d,%0d,%0d,%0d exp=250,244,244,252", obs_pix[3],
               obs_pix[4], obs_pix[5], obs_pix[7]);
    end
  endtask

  task automatic test_midframe();
    put(0, 1'b1, 1'b1, 16'hFFFF, 0, 0, 3'd0, 8'd0, 8'd255);
    put(1, 1'b1, 1'b1, 16'hFFFF, 5, 3, 3'd1, 8'd0, 8'd255);
    put(2, 1'b1, 1'b1, 16'hFFFF, 6, 3, 3'd1, 8'd0, 8'd255);
    put(3, 1'b1, 1'b1, 16'hFFFF, 0, 0, 3'd1, 8'd0, 8'd255);
    put(4, 1'b1, 1'b1, 16'hFFFF, 1, 0, 3'd0, 8'd0, 8'd255);
    run(5);
    n_checks++;
    if (obs_pix[3] !== 8'd244 || obs_pix[4] !== 8'd244 || obs_pix[5] !== 8'd244) begin
      n_fail++;
      $display("FAIL midframe_hold got=%0d,%0d,%0d exp=244,244,244", obs_pix[3], obs_pix[4],
               obs_pix[5]);
    end
    n_checks++;
    if (obs_pix[6] !== 8'd248 || obs_pix[7] !== 8'd248) begin
      n_fail++;
      $display("FAIL midframe_switch got=%0d,%0d exp=248,248", obs_pix[6], obs_pix[7]);
    end
    n_checks++;
    if (obs_hc[4] !== 11'd5 || obs_vc[4] !== 10'd3) begin
      n_fail++;
      $display("FAIL midframe_coords got=(%0d,%0d) exp=(5,3)", obs_hc[4], obs_vc[4]);
    end
  endtask

  localparam logic [15:0] KP [10] = '{16'hF9C0, 16'hF9E0, 16'hFFEE, 16'hFFCF, 16'h9820,
                                      16'h9800, 16'hFFCE, 16'hFFEE, 16'hFFD0, 16'hFFF0};
  localparam logic [7:0]  KV [10] = '{8'd99, 8'd100, 8'd200, 8'd201, 8'd50, 8'd49, 8'd199,
                                      8'd200, 8'd51, 8'd50};
  localparam logic        KM [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                                      1'b1};

  task automatic test_mask();
    for (int i = 0; i < 10; i++) begin
      if (i < 4)      put(i, 1'b1, 1'b1, KP[i], i, 0, 3'd0, 8'd100, 8'd200);
      else if (i < 8) put(i, 1'b1, 1'b1, KP[i], i - 4, 0, 3'd0, 8'd200, 8'd50);
      else            put(i, 1'b1, 1'b1, KP[i], i - 8, 0, 3'd7, 8'd200, 8'd50);
    end
    run(10);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (obs_v[i+L-1] !== 1'b1 || obs_pix[i+L-1] !== KV[i] || obs_m[i+L-1] !== KM[i]) begin
        n_fail++;
        $display("FAIL mask%0d got v=%b pix=%0d m=%b exp v=1 pix=%0d m=%b", i, obs_v[i+L-1],
                 obs_pix[i+L-1], obs_m[i+L-1], KV[i], KM[i]);
      end
    end
  endtask

  task automatic test_count();
    int ns;
    put(0, 1'b0, 1'b0, 16'h0000, 0, 0, 3'd0, 8'd100, 8'd200);
    for (int i = 0; i < 8; i++)
      put(i + 1, 1'b1, 1'b1, (i < 5) ? 16'hF9E0 : 16'hF9C0, i % 4, i / 4, 3'd0, 8'd100,
          8'd200);
    put(9,  1'b1, 1'b1, 16'hF9E0, 0, 0, 3'd0, 8'd100, 8'd200);
    put(10, 1'b1, 1'b1, 16'hF9E0, 1, 0, 3'd0, 8'd100, 8'd200);
    put(11, 1'b1, 1'b1, 16'hF9C0, 2, 0, 3'd0, 8'd100, 8'd200);
    put(12, 1'b1, 1'b1, 16'hF9C0, 0, 0, 3'd0, 8'd100, 8'd200);
    run(13);
    ns = 0;
    for (int k = 0; k < 12; k++) if (obs_fcv[k] !== 1'b0) ns++;
    n_checks++;
    if (ns != 0) begin
      n_fail++;
      $display("FAIL count_first_sof got strobes=%0d exp 0", ns);
    end
    n_checks++;
    if (obs_fcv[12] !== 1'b1 || obs_fco[12] !== 20'd5) begin
      n_fail++;
      $display("FAIL count_frame1 got fcv=%b fco=%0d exp fcv=1 fco=5", obs_fcv[12],
               obs_fco[12]);
    end
    n_checks++;
    if (obs_fcv[13] !== 1'b0 || obs_fco[13] !== 20'd5) begin
      n_fail++;
      $display("FAIL count_strobe_width got fcv=%b fco=%0d exp fcv=0 fco=5", obs_fcv[13],
               obs_fco[13]);
    end
    n_checks++;
    if (obs_fcv[15] !== 1'b1 || obs_fco[15] !== 20'd2) begin
      n_fail++;
      $display("FAIL count_frame2 got fcv=%b fco=%0d exp fcv=1 fco=2", obs_fcv[15],
               obs_fco[15]);
    end
  endtask

  task automatic test_reset_midframe();
    put(0, 1'b1, 1'b1, 16'hFFFF, 0, 0, 3'd1, 8'd10, 8'd20);
    put(1, 1'b1, 1'b1, 16'hFFFF, 1, 0, 3'd1, 8'd10, 8'd20);
    put(2, 1'b1, 1'b1, 16'hFFFF, 2, 0, 3'd1, 8'd10, 8'd20);
    put(3, 1'b1, 1'b1, 16'hFFFF, 3, 0, 3'd1, 8'd10, 8'd20);
    put(4, 1'b0, 1'b1, 16'hFFFF, 4, 0, 3'd1, 8'd10, 8'd20);
    put(5, 1'b1, 1'b1, 16'hFFFF, 1, 1, 3'd1, 8'd10, 8'd20);
    run(6);
    n_checks++;
    if (obs_v[3] !== 1'b1 || obs_pix[3] !== 8'd248 || obs_m[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_before got v=%b pix=%0d m=%b exp v=1 pix=248 m=0", obs_v[3],
               obs_pix[3], obs_m[3]);
    end
    n_checks++;
    if (obs_v[4] !== 1'b0 || obs_pix[4] !== 8'd0 || obs_m[4] !== 1'b0 || obs_hc[4] !== 11'd0
        || obs_fco[4] !== 20'd0 || obs_fcv[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_zero got v=%b pix=%0d m=%b hc=%0d fco=%0d fcv=%b exp all 0",
               obs_v[4], obs_pix[4], obs_m[4], obs_hc[4], obs_fco[4], obs_fcv[4]);
    end
    n_checks++;
    if (obs_v[5] !== 1'b0 || obs_v[6] !== 1'b0 || obs_v[7] !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_stale got=%b%b%b exp=000", obs_v[5], obs_v[6], obs_v[7]);
    end
    n_checks++;
    if (obs_v[8] !== 1'b1 || obs_pix[8] !== 8'd244 || obs_m[8] !== 1'b1
        || obs_hc[8] !== 11'd1 || obs_vc[8] !== 10'd1) begin
      n_fail++;
      $display("FAIL rstmid_defaults got v=%b pix=%0d m=%b hc=%0d vc=%0d exp 1/244/1/1/1",
               obs_v[8], obs_pix[8], obs_m[8], obs_hc[8], obs_vc[8]);
    end
  endtask

  initial begin
    rst_in      = 1'b0;
    rec_valid   = 1'b0;
    rec_pixel   = '0;
    rec_hcount  = '0;
    rec_vcount  = '0;
    selector    = '0;
    lower_bound = '0;
    upper_bound = 8'd255;
    @(posedge clk_in);
    #1;
    test_reset();
    test_modes();
    test_back_to_back();
    test_midframe();
    test_mask();
    test_count();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
